// File: rtl/complex_pkg.sv
// Shared definitions for the complex add/sub sequencer: word layout,
// op encoding, FSM state encoding and a NaN detector for IEEE-754 singles.
package complex_pkg;

  localparam int CPLX_W = 64;
  localparam int FP_W   = 32;

  // Complex word layout: {real, imag}
  localparam int RE_MSB = 63;
  localparam int RE_LSB = 32;
  localparam int IM_MSB = 31;
  localparam int IM_LSB = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_t;

  // NaN: all-ones exponent with a non-zero mantissa
  function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/sync_fifo_64.sv
// Synchronous register FIFO for 64-bit complex results. No fall-through:
// a word written to an empty FIFO reaches the head on the following cycle.
// Push and pop in the same cycle are allowed even when full.
module sync_fifo_64
  import complex_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [CPLX_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [CPLX_W-1:0]      rd_data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CPLX_W-1:0] mem [DEPTH];
  logic              do_wr;
  logic              do_rd;

  // A write into a full FIFO is only taken when a pop frees a slot
  always_comb begin
    do_rd = rd_en && (count != '0);
    do_wr = wr_en && ((count != FULL) || do_rd);
  end

  assign rd_data = mem[rd_ptr];
  assign valid   = (count != '0);

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/complex_addsub_sequencer.sv
// Job sequencer in front of a fixed-latency complex adder/subtractor.
// Accepts `len` operand pairs per job, issues them into the never-stalled
// adder pipeline, tracks in-flight results and buffers them in an output
// FIFO guarded by a credit check (FIFO occupancy + in-flight < depth).
// Optional feature macro: COMPLEX_NAN_FLAG_EN adds a sticky nan_seen output.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high; ready never depends on valid on the same interface.
module complex_addsub_sequencer
  import complex_pkg::*;
#(
  parameter int ADD_LAT    = 4,
  parameter int FIFO_DEPTH = 8,   // power of two, >= ADD_LAT
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              op_in,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [CPLX_W-1:0] in_a,
  input  logic [CPLX_W-1:0] in_b,
  output logic              in_ready,
  output logic [CPLX_W-1:0] as_a,
  output logic [CPLX_W-1:0] as_b,
  output logic              as_op,
  output logic              as_ce,
  input  logic [CPLX_W-1:0] as_result,
  output logic              out_valid,
  output logic [CPLX_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
`ifdef COMPLEX_NAN_FLAG_EN
  ,
  output logic              nan_seen
`endif
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  // Wide enough for fifo_count + inflight (<= 2*FIFO_DEPTH + 1)
  localparam int CW  = FAW + 2;

  seq_state_t        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  popped;

  // issue_q marks that as_a/as_b were loaded with a fresh pair this cycle;
  // vld_sr then follows that pair through the ADD_LAT adder stages so that
  // its tail lines up with the matching as_result.
  logic               issue_q;
  logic [ADD_LAT-1:0] vld_sr;

  logic [FAW:0]      fifo_count;
  logic [CW-1:0]     inflight;
  logic              credit_ok;
  logic              hs;
  logic              pop;
  logic              push;
  logic              head_is_last;

  assign as_ce = 1'b1;
  assign busy  = (state != ST_IDLE);
  assign push  = vld_sr[ADD_LAT-1];

  // Credit check and handshake decode
  always_comb begin
    inflight = CW'(issue_q);
    for (int i = 0; i < ADD_LAT; i++) begin
      inflight = inflight + CW'(vld_sr[i]);
    end
    credit_ok    = (CW'(fifo_count) + inflight) < CW'(FIFO_DEPTH);
    in_ready     = (state == ST_RUN) && (issued < len_q) && credit_ok;
    hs           = in_valid && in_ready;
    pop          = out_valid && out_ready;
    head_is_last = ((popped + 1'b1) == len_q);
    out_last     = out_valid && head_is_last;
  end

  // Job FSM: start/len latch, issue and pop counters, done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      len_q  <= '0;
      issued <= '0;
      popped <= '0;
      done   <= 1'b0;
      as_op  <= OP_ADD;
    end else begin
      done <= 1'b0;
      if (pop) begin
        popped <= popped + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q  <= len;
            as_op  <= op_in;
            issued <= '0;
            popped <= '0;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (hs) begin
            issued <= issued + 1'b1;
            if ((issued + 1'b1) == len_q) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_is_last) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand registers and in-flight tracking; the pipeline is never stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      as_a    <= '0;
      as_b    <= '0;
      issue_q <= 1'b0;
      vld_sr  <= '0;
    end else begin
      issue_q <= hs;
      vld_sr  <= (vld_sr << 1) | ADD_LAT'(issue_q);
      if (hs) begin
        as_a <= in_a;
        as_b <= in_b;
      end
    end
  end

  sync_fifo_64 #(
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (as_result),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .valid   (out_valid),
    .count   (fifo_count)
  );

`ifdef COMPLEX_NAN_FLAG_EN
  // Sticky NaN flag over every result written into the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_seen <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      nan_seen <= 1'b0;
    end else if (push && (fp_is_nan(as_result[RE_MSB:RE_LSB]) ||
                          fp_is_nan(as_result[IM_MSB:IM_LSB]))) begin
      nan_seen <= 1'b1;
    end
  end
`endif

endmodule
